imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side counterpart to the instruction fetch path: streams program bytes into instruction SRAM before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit words.
- Writes each word to consecutive word addresses starting from a programmable byte base address.
- Drives the same sram port set (cs/oe/we/addr/din) that the fetch path reads with `we` tied low.

Parameters:
- MAX_WORDS, 1024: maximum number of words written per load; extra words are dropped and flagged.
- ADDR_W, 32: address width, matching the sram addr width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] forced to 0 when latched.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte; first byte of a word is the MSB.
- byte_last  in  1  qualifies the final byte of the image.
- byte_ready  out  1  loader can accept a byte this cycle.
- sram_cs  out  1  sram chip select.
- sram_oe  out  1  sram output enable.
- sram_we  out  1  sram write enable.
- sram_addr  out  ADDR_W  sram byte address.
- sram_din  out  32  write data.
- sram_dout  in  32  read data; used only with IMEM_LOADER_VERIFY_EN.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle pulse at end of load.
- err  out  1  sticky error; cleared by the next accepted start or by reset.
- word_cnt  out  ADDR_W  number of words written in the current or most recent load.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - byte_ready, sram_cs, sram_oe, sram_we, busy, done and err = 0.
  - sram_addr, sram_din and word_cnt = 0.
  - The internal byte index and shift register are cleared.
  - Reset mid-load abandons the load immediately; no partial word is written.
- Byte transfer occurs only when byte_valid && byte_ready on a rising edge.
- States:
  - IDLE:
    - byte_ready=0.
    - start=1 → latch {base_addr[ADDR_W-1:2],2'b00} into sram_addr; clear word_cnt, err and byte index; busy=1; go COLLECT.
  - COLLECT:
    - byte_ready=1.
    - Each transfer does word={word[23:0],byte_data} and increments the byte index.
    - On the 4th byte, or on any byte with byte_last=1, go WRITE.
    - A short word (last byte at index k<3) is left-justified: it is shifted by 8*(3-k) so the unused low bytes are 0x00.
    - A pending last is recorded internally.
  - WRITE:
    - One cycle with sram_cs=1, sram_we=1, sram_oe=0, sram_din=word, at the current sram_addr.
    - If word_cnt==MAX_WORDS: the write strobes are suppressed (cs=we=0), err is set to 1, and the word is dropped.
    - Otherwise word_cnt increments by 1.
    - Exit: go VERIFY (macro builds only), else go DONE if last is pending, else COLLECT.
    - sram_addr += 4 on exit from the write sequence (modulo 2^ADDR_W; wrap is silent).
  - DONE:
    - done=1 for exactly one cycle; busy=0 on the following cycle.
    - byte_ready=0; return to IDLE.
- Outside WRITE/VERIFY, sram_cs=sram_we=sram_oe=0.
- start while not in IDLE is ignored.
- Latency: the 4th byte accepted at edge N → write strobe in cycle N+1 → byte_ready=1 again in cycle N+2. Peak throughput is 4 bytes per 5 cycles.
- byte_valid held low is a legal stall of any length; the byte index and word are held.
- A byte with byte_last=1 as the first byte of a word produces one word of {byte,24'h0}.
- byte_last with no prior bytes is not possible to express; an empty image is not supported.

Optional Feature:
- Macro: IMEM_LOADER_VERIFY_EN.
- Defined: adds a VERIFY state after each non-dropped WRITE.
  - Lasts 2 cycles with sram_cs=1, sram_oe=1, sram_we=0, same sram_addr.
  - sram_dout is compared against the written word in the 2nd cycle.
  - A mismatch sets err=1 (sticky); the load continues.
  - Throughput becomes 4 bytes per 7 cycles.
- Undefined: no VERIFY state, sram_dout is ignored, and sram_oe is constantly 0.

Test Plan:
- Basic load:
  - Stimulus: base_addr=0x100, bytes 12 34 56 78 9A BC DE F0 with last on F0.
  - Response: writes 0x12345678@0x100 then 0x9ABCDEF0@0x104; word_cnt=2; one done pulse; err=0.
- Short tail:
  - Stimulus: base 0x3 (forced to 0x0), bytes AA BB CC DD EE with last on EE.
  - Response: writes 0xAABBCCDD@0x0 and 0xEE000000@0x4.
- Backpressure/stall:
  - Stimulus: byte_valid random with 50% gaps, 3 words.
  - Response: same data and addresses as the gap-free run; byte_ready=0 in each WRITE cycle.
- Overflow:
  - Stimulus: MAX_WORDS=2, 12 bytes.
  - Response: exactly 2 write strobes; err=1 after the 3rd word; word_cnt=2; done pulses.
- Reset and start handling:
  - Stimulus: rst_n low after 2 bytes of a word.
  - Response: all outputs 0 immediately, no write strobe, a new start is accepted afterwards.
  - Stimulus: start pulsed during COLLECT.
  - Response: ignored.
- Verify mismatch (macro on):
  - Stimulus: sram model corrupts bit 0 of the word at 0x104.
  - Response: err=1 after the VERIFY of word 2; all words are still written; done pulses.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into instruction SRAM as consecutive 32-bit words.
// Optional read-back check of every written word: define IMEM_LOADER_VERIFY_EN.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [1:0]  idx;
    logic [31:0] word;
    logic        last_pend;
    logic        xfer;
    logic        drop;
    logic [31:0] packed_word;
    logic [31:0] word_next;

`ifdef IMEM_LOADER_VERIFY_EN
    logic        vcnt;
`else
    logic        unused_dout;
    assign unused_dout = ^sram_dout;
`endif

    assign xfer = byte_valid && byte_ready;
    assign drop = (word_cnt == ADDR_W'(MAX_WORDS));

    // Next-state decode and byte packing; a short final word is left-justified.
    always_comb begin
        state_next  = state;
        packed_word = {word[23:0], byte_data};
        word_next   = packed_word;
        if (byte_last) begin
            word_next = packed_word << {2'd3 - idx, 3'b000};
        end
        case (state)
            S_IDLE: begin
                if (start) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (xfer && (idx == 2'd3 || byte_last)) state_next = S_WRITE;
            end
            S_WRITE: begin
`ifdef IMEM_LOADER_VERIFY_EN
                if (!drop)          state_next = S_VERIFY;
                else if (last_pend) state_next = S_DONE;
                else                state_next = S_COLLECT;
`else
                state_next = last_pend ? S_DONE : S_COLLECT;
`endif
            end
            S_VERIFY: begin
`ifdef IMEM_LOADER_VERIFY_EN
                if (vcnt) state_next = last_pend ? S_DONE : S_COLLECT;
`else
                state_next = S_IDLE;
`endif
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register with registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            sram_cs    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            idx        <= '0;
            word       <= '0;
            last_pend  <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            vcnt       <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            byte_ready <= (state_next == S_COLLECT);
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
            sram_cs    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;

            // A word past the limit still walks through WRITE, but with strobes off.
            if (state_next == S_WRITE) begin
                sram_cs  <= !drop;
                sram_we  <= !drop;
                sram_din <= word_next;
            end
`ifdef IMEM_LOADER_VERIFY_EN
            if (state_next == S_VERIFY) begin
                sram_cs <= 1'b1;
                sram_oe <= 1'b1;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sram_addr <= {base_addr[ADDR_W-1:2], 2'b00};
                        word_cnt  <= '0;
                        err       <= 1'b0;
                        idx       <= '0;
                        word      <= '0;
                        last_pend <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        word <= word_next;
                        idx  <= idx + 2'd1;
                        if (byte_last) last_pend <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (drop) err <= 1'b1;
                    else      word_cnt <= word_cnt + ADDR_W'(1);
`ifdef IMEM_LOADER_VERIFY_EN
                    vcnt <= 1'b0;
`endif
                    if (state_next != S_VERIFY) sram_addr <= sram_addr + ADDR_W'(4);
                end
                S_VERIFY: begin
`ifdef IMEM_LOADER_VERIFY_EN
                    vcnt <= 1'b1;
                    if (vcnt) begin
                        if (sram_dout != sram_din) err <= 1'b1;
                        sram_addr <= sram_addr + ADDR_W'(4);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
